// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction memory and its byte-stream loader.
// Optional feature macro: INST_MEM_CHECKSUM_EN (adds the CSUM loader state).
package inst_mem_pkg;

  localparam logic [31:0] NOP       = 32'h00000013;
  localparam int          LEN_BYTES = 4;

`ifdef INST_MEM_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE} ld_state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_DONE} ld_state_t;
`endif

endpackage

// File: rtl/inst_mem_ld_word_asm.sv
// Little-endian byte-to-word assembler shared by the length field and the
// program words. The first byte of a group lands in bits [7:0].
module ld_word_asm
  import inst_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_byte_vld,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  localparam logic [1:0] LAST_IDX = 2'(LEN_BYTES - 1);

  logic [1:0]  r_idx;
  logic [23:0] r_buf;

  // Byte index within the current word; wraps to 0 after the last byte.
  always_ff @(posedge clk) begin
    if (!rst || i_clr) r_idx <= '0;
    else if (i_byte_vld) r_idx <= r_idx + 2'd1;
  end

  // Shift buffer holding the lower three bytes of the word in progress.
  always_ff @(posedge clk) begin
    if (i_byte_vld) r_buf <= {i_byte, r_buf[23:8]};
  end

  assign o_word_valid = i_byte_vld && (r_idx == LAST_IDX);
  assign o_word       = {i_byte, r_buf};

endmodule

// File: rtl/inst_mem.sv
// Instruction memory with combinational fetch port and byte-stream loader.
// Optional feature macro: INST_MEM_CHECKSUM_EN (8-bit load checksum).
//
// state  | meaning
// S_IDLE | core runs; waiting for ld_start_i
// S_LEN  | collecting the 4-byte word count N
// S_DATA | collecting N program words
// S_CSUM | collecting the checksum byte (checksum build only)
// S_DONE | one-cycle completion pulse, core still held
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_o,
  output logic        addr_err_o,
  input  logic        ld_start_i,
  input  logic        ld_valid_i,
  input  logic [7:0]  ld_data_i,
  output logic        ld_ready_o,
  output logic        core_hold_o,
  output logic        ld_done_o,
  output logic        ld_err_o
);

`ifdef INST_MEM_CHECKSUM_EN
  localparam ld_state_t S_POST = S_CSUM;
`else
  localparam ld_state_t S_POST = S_DONE;
`endif

  logic [31:0] r_mem [DEPTH_WORDS];
  ld_state_t   r_state, w_state_nxt;
  logic [31:0] r_n;
  logic [31:0] r_wcnt;
  logic        r_err;
`ifdef INST_MEM_CHECKSUM_EN
  logic [7:0]  r_sum;
  logic [7:0]  w_csum;
`endif

  logic        w_acc, w_asm_vld, w_word_valid, w_last_word, w_in_depth, w_mem_we;
  logic        w_aligned, w_in_range;
  logic [31:0] w_word;

  assign ld_ready_o  = (r_state == S_LEN) || (r_state == S_DATA)
`ifdef INST_MEM_CHECKSUM_EN
                       || (r_state == S_CSUM)
`endif
                       ;
  assign core_hold_o = (r_state != S_IDLE);
  assign ld_done_o   = (r_state == S_DONE);
  assign ld_err_o    = r_err;

  assign w_acc       = ld_valid_i && ld_ready_o;
  assign w_asm_vld   = w_acc && ((r_state == S_LEN) || (r_state == S_DATA));
  assign w_last_word = ((r_wcnt + 32'd1) == r_n);
  assign w_in_depth  = (r_wcnt < 32'(DEPTH_WORDS));
  assign w_mem_we    = rst && (r_state == S_DATA) && w_word_valid && w_in_depth;
`ifdef INST_MEM_CHECKSUM_EN
  assign w_csum      = r_sum + ld_data_i;
`endif

  ld_word_asm u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (r_state == S_IDLE),
    .i_byte_vld   (w_asm_vld),
    .i_byte       (ld_data_i),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // Loader state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Loader next-state decode; a zero-length load skips DATA entirely.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (ld_start_i) w_state_nxt = S_LEN;
      S_LEN:  if (w_word_valid) w_state_nxt = (w_word == 32'd0) ? S_POST : S_DATA;
      S_DATA: if (w_word_valid && w_last_word) w_state_nxt = S_POST;
`ifdef INST_MEM_CHECKSUM_EN
      S_CSUM: if (w_acc) w_state_nxt = S_DONE;
`endif
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Length, word counter and sticky error; the counter doubles as write pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_n    <= '0;
      r_wcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (ld_start_i) begin
          r_wcnt <= '0;
          r_err  <= 1'b0;
        end
        S_LEN:  if (w_word_valid) r_n <= w_word;
        S_DATA: if (w_word_valid) begin
          r_wcnt <= r_wcnt + 32'd1;
          if (!w_in_depth) r_err <= 1'b1;
        end
`ifdef INST_MEM_CHECKSUM_EN
        S_CSUM: if (w_acc && (w_csum != 8'd0)) r_err <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

`ifdef INST_MEM_CHECKSUM_EN
  // Running mod-256 sum over every LEN and DATA byte of the current load.
  always_ff @(posedge clk) begin
    if (!rst || ((r_state == S_IDLE) && ld_start_i)) r_sum <= '0;
    else if (w_asm_vld) r_sum <= w_csum;
  end
`endif

  // Program array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_wcnt[AW-1:0]] <= w_word;
  end

  assign w_aligned  = (inst_addr_i[1:0] == 2'b00);
  assign w_in_range = (inst_addr_i[31:AW+2] == '0);

  // Fetch port: NOP while held, NOP plus error on a bad address.
  always_comb begin
    inst_o     = NOP;
    addr_err_o = 1'b0;
    if (!core_hold_o) begin
      if (w_aligned && w_in_range) inst_o = r_mem[inst_addr_i[AW+1:2]];
      else addr_err_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_mem.sv
// Directed bench for inst_mem: fetch decode, loads, overflow, mid-load reset.
module tb_inst_mem;
  import inst_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_addr_i = '0;
  logic [31:0] inst_o;
  logic        addr_err_o;
  logic        ld_start_i = 1'b0;
  logic        ld_valid_i = 1'b0;
  logic [7:0]  ld_data_i = '0;
  logic        ld_ready_o, core_hold_o, ld_done_o, ld_err_o;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [7:0]  tb_sum   = '0;

  inst_mem #(.DEPTH_WORDS(4096)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_addr_i (inst_addr_i),
    .inst_o      (inst_o),
    .addr_err_o  (addr_err_o),
    .ld_start_i  (ld_start_i),
    .ld_valid_i  (ld_valid_i),
    .ld_data_i   (ld_data_i),
    .ld_ready_o  (ld_ready_o),
    .core_hold_o (core_hold_o),
    .ld_done_o   (ld_done_o),
    .ld_err_o    (ld_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] a,
                       input logic [31:0] exp_inst, input logic exp_err);
    inst_addr_i = a;
    #1;
    check(tag, inst_o, exp_inst);
    check1({tag, "_err"}, addr_err_o, exp_err);
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_valid_i = 1'b1;
    ld_data_i  = b;
    for (int k = 0; k < 20 && !ld_ready_o; k++) tick();
    if (!ld_ready_o) check1("ready_timeout", ld_ready_o, 1'b1);
    tb_sum = tb_sum + b;
    tick();
    ld_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic start_load(input string tag);
    ld_start_i = 1'b1;
    tick();
    ld_start_i = 1'b0;
    tb_sum = '0;
    check1({tag, "_ready"}, ld_ready_o, 1'b1);
    check1({tag, "_hold"}, core_hold_o, 1'b1);
    check1({tag, "_err_clr"}, ld_err_o, 1'b0);
  endtask

  // Sends the checksum byte when that feature is built, then checks DONE and release.
  task automatic finish_load(input string tag, input logic exp_err);
`ifdef INST_MEM_CHECKSUM_EN
    send_byte(8'(8'd0 - tb_sum));
`endif
    check1({tag, "_done"}, ld_done_o, 1'b1);
    check1({tag, "_done_hold"}, core_hold_o, 1'b1);
    fetch({tag, "_held_fetch"}, 32'h0, NOP, 1'b0);
    tick();
    check1({tag, "_done_once"}, ld_done_o, 1'b0);
    check1({tag, "_release"}, core_hold_o, 1'b0);
    check1({tag, "_err"}, ld_err_o, exp_err);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    rst = 1'b1;
    tick();

    check1("rst_hold",  core_hold_o, 1'b0);
    check1("rst_ready", ld_ready_o,  1'b0);
    check1("rst_done",  ld_done_o,   1'b0);
    check1("rst_err",   ld_err_o,    1'b0);

    inst_addr_i = 32'h0; #1; check1("f0_err", addr_err_o, 1'b0);
    inst_addr_i = 32'h4; #1; check1("f4_err", addr_err_o, 1'b0);
    fetch("f_mis2",   32'h0000_0002, NOP, 1'b1);
    fetch("f_oor",    32'h0000_4000, NOP, 1'b1);
    tick();
    fetch("f_mis1",   32'h0000_0001, NOP, 1'b1);
    fetch("f_high",   32'hFFFF_FFFC, NOP, 1'b1);
    inst_addr_i = 32'h3FFC; #1; check1("f_last_err", addr_err_o, 1'b0);
    tick();

    // Two-word program load.
    start_load("n2");
    send_word(32'd2);
    send_word(32'h0050_0093);
    send_word(32'h0010_8113);
    finish_load("n2", 1'b0);
    fetch("n2_w0", 32'h0, 32'h0050_0093, 1'b0);
    fetch("n2_w1", 32'h4, 32'h0010_8113, 1'b0);
    tick();

    // Zero-length load goes straight from LEN to completion.
    start_load("n0");
    send_word(32'd0);
    finish_load("n0", 1'b0);
    fetch("n0_w0", 32'h0, 32'h0050_0093, 1'b0);
    fetch("n0_w1", 32'h4, 32'h0010_8113, 1'b0);
    tick();

    // One word past the array: the extra word is dropped and flags an error.
    start_load("ovf");
    send_word(32'd4097);
    for (int i = 0; i < 4096; i++) send_word(32'hC000_0000 + 32'(i));
    check1("ovf_err_before", ld_err_o, 1'b0);
    check1("ovf_still_data", ld_ready_o, 1'b1);
    send_word(32'hC000_1000);
    finish_load("ovf", 1'b1);
    fetch("ovf_w0",    32'h0,    32'hC000_0000, 1'b0);
    fetch("ovf_w1",    32'h4,    32'hC000_0001, 1'b0);
    fetch("ovf_wlast", 32'h3FFC, 32'hC000_0FFF, 1'b0);
    tick();

    // Reset after six DATA bytes of a two-word load.
    start_load("mid");
    send_word(32'd2);
    send_word(32'h1122_3344);
    send_byte(8'hAA);
    send_byte(8'hBB);
    check1("mid_hold_pre", core_hold_o, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check1("mid_hold",  core_hold_o, 1'b0);
    check1("mid_ready", ld_ready_o,  1'b0);
    fetch("mid_w0", 32'h0, 32'h1122_3344, 1'b0);
    fetch("mid_w1", 32'h4, 32'hC000_0001, 1'b0);
    tick();

    // Bytes offered while idle are dropped.
    ld_valid_i = 1'b1;
    ld_data_i  = 8'h55;
    tick();
    tick();
    ld_valid_i = 1'b0;
    check1("idle_drop_ready", ld_ready_o, 1'b0);
    check1("idle_drop_hold",  core_hold_o, 1'b0);

    // Fresh load after the interrupted one assembles from a clean byte index.
    start_load("n1");
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    finish_load("n1", 1'b0);
    fetch("n1_w0", 32'h0, 32'hDEAD_BEEF, 1'b0);
    fetch("n1_w1", 32'h4, 32'hC000_0001, 1'b0);
    tick();

`ifdef INST_MEM_CHECKSUM_EN
    // Checksum off by one.
    start_load("cs_bad");
    send_word(32'd1);
    send_word(32'h1234_5678);
    send_byte(8'(8'd0 - tb_sum) + 8'd1);
    check1("cs_bad_done", ld_done_o, 1'b1);
    tick();
    check1("cs_bad_err", ld_err_o, 1'b1);
    fetch("cs_bad_w0", 32'h0, 32'h1234_5678, 1'b0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
